// File: rtl/cam_learn_ctrl_if.sv
// Request/response handshake bundle between a table manager
// and cam_learn_ctrl.
interface cam_learn_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_op;
    logic [DATA_WIDTH-1:0] req_key;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_status;
    logic [ADDR_WIDTH-1:0] rsp_addr;

    modport master (
        output req_valid, req_op, req_key, rsp_ready,
        input  req_ready, rsp_valid, rsp_status, rsp_addr
    );

    modport slave (
        input  req_valid, req_op, req_key, rsp_ready,
        output req_ready, rsp_valid, rsp_status, rsp_addr
    );
endinterface

// File: rtl/cam_learn_ctrl.sv
// Write-side controller for cam_core: flushes the table after reset,
// then serves insert/delete requests with a free-slot bitmap.
module cam_learn_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    cam_learn_ctrl_if.slave       bus,
    output logic [ADDR_WIDTH:0]   used_count,
    output logic                  init_busy,
    output logic                  cam_we,
    output logic [ADDR_WIDTH-1:0] cam_addr,
    output logic [DATA_WIDTH-1:0] cam_data,
    output logic                  cam_valid,
    output logic [DATA_WIDTH-1:0] lookup_data,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    input  logic                  lookup_hit
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    localparam logic [1:0] ST_OK        = 2'd0;
    localparam logic [1:0] ST_EXISTS    = 2'd1;
    localparam logic [1:0] ST_FULL      = 2'd2;
    localparam logic [1:0] ST_NOT_FOUND = 2'd3;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_LOOKUP,
        S_CHECK,
        S_WRITE,
        S_RESP
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] sweep;
    logic [DEPTH-1:0]      bitmap;
    logic                  op_q;
    logic [ADDR_WIDTH-1:0] target;
    logic                  req_ready;
    logic                  rsp_valid;
    logic [1:0]            rsp_status;
    logic [ADDR_WIDTH-1:0] rsp_addr;
    logic [ADDR_WIDTH-1:0] free_idx;
    logic                  free_any;

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_status = rsp_status;
    assign bus.rsp_addr   = rsp_addr;

    // Lowest-index clear bit wins; scanning downward leaves it last.
    always_comb begin
        free_idx = '0;
        free_any = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!bitmap[i]) begin
                free_idx = ADDR_WIDTH'(i);
                free_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_INIT;
            sweep       <= '0;
            bitmap      <= '0;
            used_count  <= '0;
            op_q        <= 1'b0;
            target      <= '0;
            lookup_data <= '0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_status  <= ST_OK;
            rsp_addr    <= '0;
            init_busy   <= 1'b1;
            cam_we      <= 1'b0;
            cam_addr    <= '0;
            cam_data    <= '0;
            cam_valid   <= 1'b0;
        end else begin
            cam_we <= 1'b0;
            unique case (state)
                S_INIT: begin
                    cam_we    <= 1'b1;
                    cam_addr  <= sweep;
                    cam_data  <= '0;
                    cam_valid <= 1'b0;
                    sweep     <= sweep + 1'b1;
                    if (sweep == LAST) begin
                        state     <= S_IDLE;
                        init_busy <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (bus.req_valid && req_ready) begin
                        op_q        <= bus.req_op;
                        lookup_data <= bus.req_key;
                        req_ready   <= 1'b0;
                        state       <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    unique case (1'b1)
                        !op_q && lookup_hit: begin
                            rsp_status <= ST_EXISTS;
                            rsp_addr   <= lookup_addr;
                            rsp_valid  <= 1'b1;
                            state      <= S_RESP;
                        end
                        !op_q && !lookup_hit && !free_any: begin
                            rsp_status <= ST_FULL;
                            rsp_addr   <= '0;
                            rsp_valid  <= 1'b1;
                            state      <= S_RESP;
                        end
                        !op_q && !lookup_hit && free_any: begin
                            target    <= free_idx;
                            cam_we    <= 1'b1;
                            cam_addr  <= free_idx;
                            cam_data  <= lookup_data;
                            cam_valid <= 1'b1;
                            state     <= S_WRITE;
                        end
                        op_q && lookup_hit: begin
                            target    <= lookup_addr;
                            cam_we    <= 1'b1;
                            cam_addr  <= lookup_addr;
                            cam_data  <= '0;
                            cam_valid <= 1'b0;
                            state     <= S_WRITE;
                        end
                        op_q && !lookup_hit: begin
                            rsp_status <= ST_NOT_FOUND;
                            rsp_addr   <= '0;
                            rsp_valid  <= 1'b1;
                            state      <= S_RESP;
                        end
                        default: begin
                            state <= S_IDLE;
                            req_ready <= 1'b1;
                        end
                    endcase
                end
                S_WRITE: begin
                    bitmap[target] <= !op_q;
                    if (op_q) begin
                        used_count <= used_count - 1'b1;
                    end else begin
                        used_count <= used_count + 1'b1;
                    end
                    rsp_status <= ST_OK;
                    rsp_addr   <= target;
                    rsp_valid  <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cam_learn_ctrl.sv
// Randomized bench for cam_learn_ctrl: behavioural CAM stand-in plus
// a table-level reference model of insert/delete outcomes.
module tb_cam_learn_ctrl;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW:0]   used_count;
    logic          init_busy;
    logic          cam_we;
    logic [AW-1:0] cam_addr;
    logic [DW-1:0] cam_data;
    logic          cam_valid;
    logic [DW-1:0] lookup_data;
    logic [AW-1:0] lookup_addr;
    logic          lookup_hit;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cam_learn_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    cam_learn_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .used_count (used_count),
        .init_busy  (init_busy),
        .cam_we     (cam_we),
        .cam_addr   (cam_addr),
        .cam_data   (cam_data),
        .cam_valid  (cam_valid),
        .lookup_data(lookup_data),
        .lookup_addr(lookup_addr),
        .lookup_hit (lookup_hit)
    );

    // CAM stand-in, starting full of stale entries so only the flush clears them.
    logic [DW-1:0] cm_key[DEPTH] = '{default: 32'hDEADBEEF};
    logic          cm_vld[DEPTH] = '{default: 1'b1};

    always @(posedge clk) begin
        logic          h;
        logic [AW-1:0] a;
        h = 1'b0;
        a = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!h && cm_vld[i] && cm_key[i] == lookup_data) begin
                h = 1'b1;
                a = AW'(i);
            end
        end
        lookup_hit  <= h;
        lookup_addr <= a;
        if (cam_we) begin
            cm_key[cam_addr] <= cam_data;
            cm_vld[cam_addr] <= cam_valid;
        end
    end

    // Reference model: which keys the table holds, and where.
    logic [DW-1:0] m_key[DEPTH];
    bit            m_vld[DEPTH];

    function automatic int ref_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_vld[i]);
        return c;
    endfunction

    function automatic int ref_find(input logic [DW-1:0] k);
        for (int i = 0; i < DEPTH; i++) begin
            if (m_vld[i] && m_key[i] == k) return i;
        end
        return -1;
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_vld[i] = 1'b0;
            m_key[i] = '0;
        end
    endtask

    task automatic ref_apply(input bit op, input logic [DW-1:0] key,
                             output logic [1:0] st, output logic [AW-1:0] ad,
                             output bit wr);
        int hit;
        int fr;
        hit = ref_find(key);
        fr = -1;
        for (int i = DEPTH - 1; i >= 0; i--) if (!m_vld[i]) fr = i;
        st = 2'd0;
        ad = '0;
        wr = 1'b0;
        if (!op) begin
            if (hit >= 0) begin
                st = 2'd1;
                ad = AW'(hit);
            end else if (fr < 0) begin
                st = 2'd2;
            end else begin
                ad = AW'(fr);
                wr = 1'b1;
                m_vld[fr] = 1'b1;
                m_key[fr] = key;
            end
        end else begin
            if (hit < 0) begin
                st = 2'd3;
            end else begin
                ad = AW'(hit);
                wr = 1'b1;
                m_vld[hit] = 1'b0;
            end
        end
    endtask

    // Issues one request; lat counts the accept edge as cycle 1.
    task automatic do_req(input bit op, input logic [DW-1:0] key,
                          output logic [1:0] st, output logic [AW-1:0] ad,
                          output int lat, output int nwe,
                          output logic [AW-1:0] wa, output logic wv,
                          output logic [DW-1:0] wd);
        int n;
        nwe = 0;
        wa = '0;
        wv = 1'b0;
        wd = '0;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b1;
        bus.req_op = op;
        bus.req_key = key;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_key = $urandom;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            if (cam_we) begin
                nwe++;
                wa = cam_addr;
                wv = cam_valid;
                wd = cam_data;
            end
            @(negedge clk);
            lat++;
        end
        st = bus.rsp_status;
        ad = bus.rsp_addr;
        if (bus.rsp_ready) @(negedge clk);
    endtask

    task automatic test_flush();
        logic exp_we;
        logic exp_rdy;
        reset = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            exp_we = (k <= 32);
            exp_rdy = (k >= 32);
            total++;
            if (cam_we !== exp_we || bus.req_ready !== exp_rdy ||
                init_busy !== (k < 32) || bus.rsp_valid !== 1'b0 ||
                (exp_we && (cam_addr !== AW'(k - 1) || cam_valid !== 1'b0 ||
                            cam_data !== '0))) begin
                bad++;
                $display("FAIL flush cycle=%0d got we=%0b addr=%0d v=%0b rdy=%0b busy=%0b rspv=%0b want we=%0b addr=%0d rdy=%0b",
                         k, cam_we, cam_addr, cam_valid, bus.req_ready, init_busy,
                         bus.rsp_valid, exp_we, k - 1, exp_rdy);
            end
        end
        total++;
        if (used_count !== '0) begin
            bad++;
            $display("FAIL flush_used got=%0d want=0", used_count);
        end
        ref_clear();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op = 1'b0;
        bus.req_key = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.req_ready, bus.rsp_valid, cam_we, init_busy} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_ctl got rdy/rspv/we/busy=%b want=0001",
                     {bus.req_ready, bus.rsp_valid, cam_we, init_busy});
        end
        total++;
        if ({used_count, bus.rsp_status, bus.rsp_addr} !== '0) begin
            bad++;
            $display("FAIL reset_regs got used=%0d st=%0d addr=%0d want 0",
                     used_count, bus.rsp_status, bus.rsp_addr);
        end
        total++;
        if (lookup_data !== '0) begin
            bad++;
            $display("FAIL reset_lookup got=%h want=0", lookup_data);
        end
        test_flush();
    endtask

    task automatic test_insert_basic();
        logic [1:0] st, es;
        logic [AW-1:0] ad, ea, wa;
        logic wv;
        logic [DW-1:0] wd;
        int lat, nwe;
        bit ew;
        ref_apply(1'b0, 32'hDEADBEEF, es, ea, ew);
        do_req(1'b0, 32'hDEADBEEF, st, ad, lat, nwe, wa, wv, wd);
        total++;
        if ({st, ad} !== {2'd0, 5'd0}) begin
            bad++;
            $display("FAIL ins_rsp got st=%0d addr=%0d want st=0 addr=0", st, ad);
        end
        total++;
        if (lat != 4 || nwe != 1) begin
            bad++;
            $display("FAIL ins_timing got lat=%0d writes=%0d want lat=4 writes=1", lat, nwe);
        end
        total++;
        if ({wa, wv, wd} !== {5'd0, 1'b1, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL ins_write got addr=%0d v=%0b d=%h want 0/1/deadbeef", wa, wv, wd);
        end
        total++;
        if (used_count !== 6'd1 || lookup_data !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL ins_used got used=%0d key=%h want 1/deadbeef", used_count, lookup_data);
        end
        ref_apply(1'b0, 32'hDEADBEEF, es, ea, ew);
        do_req(1'b0, 32'hDEADBEEF, st, ad, lat, nwe, wa, wv, wd);
        total++;
        if ({st, ad} !== {2'd1, 5'd0}) begin
            bad++;
            $display("FAIL dup_rsp got st=%0d addr=%0d want st=1 addr=0", st, ad);
        end
        total++;
        if (lat != 3 || nwe != 0 || used_count !== 6'd1) begin
            bad++;
            $display("FAIL dup_timing got lat=%0d writes=%0d used=%0d want 3/0/1", lat, nwe, used_count);
        end
    endtask

    task automatic test_full();
        logic [1:0] st, es;
        logic [AW-1:0] ad, ea, wa;
        logic wv;
        logic [DW-1:0] wd, k;
        int lat, nwe;
        bit ew;
        for (int i = 1; i < DEPTH; i++) begin
            k = $urandom;
            while (ref_find(k) >= 0 || k == 32'h12345678 || k == 32'hCAFEF00D) k = $urandom;
            ref_apply(1'b0, k, es, ea, ew);
            do_req(1'b0, k, st, ad, lat, nwe, wa, wv, wd);
            total++;
            if (st !== 2'd0 || ad !== ea || lat != 4 || wa !== ea ||
                used_count !== 6'(i + 1)) begin
                bad++;
                $display("FAIL fill_%0d got st=%0d addr=%0d lat=%0d waddr=%0d used=%0d want 0/%0d/4/%0d/%0d",
                         i, st, ad, lat, wa, used_count, ea, ea, i + 1);
            end
        end
        ref_apply(1'b0, 32'h12345678, es, ea, ew);
        do_req(1'b0, 32'h12345678, st, ad, lat, nwe, wa, wv, wd);
        total++;
        if ({st, ad} !== {2'd2, 5'd0} || lat != 3 || nwe != 0) begin
            bad++;
            $display("FAIL full_rsp got st=%0d addr=%0d lat=%0d writes=%0d want 2/0/3/0",
                     st, ad, lat, nwe);
        end
        k = m_key[5];
        ref_apply(1'b1, k, es, ea, ew);
        do_req(1'b1, k, st, ad, lat, nwe, wa, wv, wd);
        total++;
        if ({st, ad} !== {2'd0, 5'd5} || {wa, wv, wd} !== {5'd5, 1'b0, 32'd0} ||
            lat != 4 || used_count !== 6'd31) begin
            bad++;
            $display("FAIL del5 got st=%0d addr=%0d waddr=%0d v=%0b d=%h lat=%0d used=%0d want 0/5/5/0/0/4/31",
                     st, ad, wa, wv, wd, lat, used_count);
        end
        ref_apply(1'b0, 32'h12345678, es, ea, ew);
        do_req(1'b0, 32'h12345678, st, ad, lat, nwe, wa, wv, wd);
        total++;
        if ({st, ad} !== {2'd0, 5'd5} || {wa, wv, wd} !== {5'd5, 1'b1, 32'h12345678} ||
            used_count !== 6'd32) begin
            bad++;
            $display("FAIL refill got st=%0d addr=%0d waddr=%0d v=%0b d=%h used=%0d want 0/5/5/1/12345678/32",
                     st, ad, wa, wv, wd, used_count);
        end
    endtask

    task automatic test_not_found_hold();
        logic [1:0] st, es;
        logic [AW-1:0] ad, ea, wa;
        logic wv;
        logic [DW-1:0] wd;
        int lat, nwe, cnt;
        bit ew;
        bus.rsp_ready = 1'b0;
        ref_apply(1'b1, 32'hCAFEF00D, es, ea, ew);
        cnt = ref_count();
        do_req(1'b1, 32'hCAFEF00D, st, ad, lat, nwe, wa, wv, wd);
        total++;
        if ({st, ad} !== {2'd3, 5'd0} || lat != 3 || nwe != 0) begin
            bad++;
            $display("FAIL nf_rsp got st=%0d addr=%0d lat=%0d writes=%0d want 3/0/3/0",
                     st, ad, lat, nwe);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({bus.rsp_valid, bus.rsp_status, bus.rsp_addr, bus.req_ready, cam_we} !==
                {1'b1, 2'd3, 5'd0, 1'b0, 1'b0} || used_count !== 6'(cnt)) begin
                bad++;
                $display("FAIL nf_hold_%0d got v=%0b st=%0d addr=%0d rdy=%0b we=%0b used=%0d want 1/3/0/0/0/%0d",
                         i, bus.rsp_valid, bus.rsp_status, bus.rsp_addr,
                         bus.req_ready, cam_we, used_count, cnt);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
            bad++;
            $display("FAIL nf_release got v=%0b rdy=%0b want 0/1", bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] pool[40];
        logic [1:0] st, es;
        logic [AW-1:0] ad, ea, wa;
        logic wv;
        logic [DW-1:0] wd, k, ewd;
        int lat, nwe;
        bit ew, op;
        for (int i = 0; i < 32; i++) pool[i] = m_key[i];
        for (int i = 32; i < 40; i++) begin
            pool[i] = (i == 32) ? '0 : $urandom;
            while (i != 32 && ref_find(pool[i]) >= 0) pool[i] = $urandom;
        end
        for (int n = 0; n < 80; n++) begin
            op = 1'($urandom_range(0, 1));
            k = pool[$urandom_range(0, 39)];
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            ref_apply(op, k, es, ea, ew);
            ewd = op ? '0 : k;
            do_req(op, k, st, ad, lat, nwe, wa, wv, wd);
            total++;
            if (st !== es || ad !== ea) begin
                bad++;
                $display("FAIL rnd_rsp n=%0d op=%0d key=%h got st=%0d addr=%0d want st=%0d addr=%0d",
                         n, op, k, st, ad, es, ea);
            end
            total++;
            if (lat != (ew ? 4 : 3) || nwe != int'(ew)) begin
                bad++;
                $display("FAIL rnd_timing n=%0d got lat=%0d writes=%0d want lat=%0d writes=%0d",
                         n, lat, nwe, ew ? 4 : 3, int'(ew));
            end
            if (ew) begin
                total++;
                if ({wa, wv, wd} !== {ea, !op, ewd}) begin
                    bad++;
                    $display("FAIL rnd_write n=%0d got addr=%0d v=%0b d=%h want addr=%0d v=%0b d=%h",
                             n, wa, wv, wd, ea, !op, ewd);
                end
            end
            total++;
            if (used_count !== 6'(ref_count())) begin
                bad++;
                $display("FAIL rnd_used n=%0d got=%0d want=%0d", n, used_count, ref_count());
            end
            if (!bus.rsp_ready) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                total++;
                if ({bus.rsp_valid, bus.rsp_status, bus.rsp_addr} !== {1'b1, es, ea}) begin
                    bad++;
                    $display("FAIL rnd_hold n=%0d got v=%0b st=%0d addr=%0d want 1/%0d/%0d",
                             n, bus.rsp_valid, bus.rsp_status, bus.rsp_addr, es, ea);
                end
                bus.rsp_ready = 1'b1;
                @(negedge clk);
            end
        end
        bus.rsp_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [1:0] st, es;
        logic [AW-1:0] ad, ea, wa;
        logic wv;
        logic [DW-1:0] wd, k;
        int lat, nwe, n;
        bit ew, op;
        op = (ref_count() == DEPTH);
        k = op ? m_key[0] : 32'h0BADF00D;
        while (!op && ref_find(k) >= 0) k = $urandom;
        bus.req_valid = 1'b1;
        bus.req_op = op;
        bus.req_key = k;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!cam_we && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (cam_we !== 1'b1) begin
            bad++;
            $display("FAIL mid_write_seen got we=%0b want 1", cam_we);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.rsp_valid, cam_we, init_busy, bus.req_ready} !== 4'b0010 ||
            used_count !== '0) begin
            bad++;
            $display("FAIL mid_write_reset got v=%0b we=%0b busy=%0b rdy=%0b used=%0d want 0/0/1/0/0",
                     bus.rsp_valid, cam_we, init_busy, bus.req_ready, used_count);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 18; i++) @(negedge clk);
        total++;
        if ({cam_we, cam_addr} !== {1'b1, 5'd17}) begin
            bad++;
            $display("FAIL mid_sweep_pos got we=%0b addr=%0d want 1/17", cam_we, cam_addr);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.rsp_valid, cam_we, init_busy} !== 3'b001 || used_count !== '0) begin
            bad++;
            $display("FAIL mid_sweep_reset got v=%0b we=%0b busy=%0b used=%0d want 0/0/1/0",
                     bus.rsp_valid, cam_we, init_busy, used_count);
        end
        test_flush();
        ref_apply(1'b0, 32'h5A5A0000, es, ea, ew);
        do_req(1'b0, 32'h5A5A0000, st, ad, lat, nwe, wa, wv, wd);
        total++;
        if ({st, ad, wa} !== {2'd0, 5'd0, 5'd0} || lat != 4 || used_count !== 6'd1) begin
            bad++;
            $display("FAIL post_reset_ins got st=%0d addr=%0d waddr=%0d lat=%0d used=%0d want 0/0/0/4/1",
                     st, ad, wa, lat, used_count);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_insert_basic();
        test_full();
        test_not_found_hold();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cam_learn_ctrl.md
# cam_learn_ctrl

Write-side controller for `cam_core`: accepts insert/delete key requests, checks the key through the CAM lookup port, allocates or frees entries via a free-slot bitmap, and drives the CAM write port. After reset it flushes every CAM entry to invalid, since the CAM table itself has no reset. Sits between the table-management/software request path and `cam_core`, which it owns exclusively on both the write and lookup sides.

## Interface
- DATA_WIDTH, 32, key width; must match `cam_core`
- ADDR_WIDTH, 5, CAM address width; DEPTH = 2**ADDR_WIDTH entries
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  1  0 = insert, 1 = delete
- req_key  in  DATA_WIDTH  key to insert or delete
- rsp_valid  out  1  response present; held until rsp_ready
- rsp_ready  in  1  response consumer ready
- rsp_status  out  2  0 = OK, 1 = EXISTS, 2 = FULL, 3 = NOT_FOUND
- rsp_addr  out  ADDR_WIDTH  entry affected or matched; 0 for FULL and NOT_FOUND
- used_count  out  ADDR_WIDTH+1  number of valid entries, 0..DEPTH
- init_busy  out  1  high while the flush sweep runs
- cam_we, cam_addr[ADDR_WIDTH], cam_data[DATA_WIDTH], cam_valid  out  CAM write port
- lookup_data  out  DATA_WIDTH  CAM lookup key
- lookup_addr  in  ADDR_WIDTH; lookup_hit  in  1  CAM lookup result, registered one cycle after lookup_data

## Operation
- States: INIT, IDLE, LOOKUP, CHECK, WRITE, RESP.
- **INIT**
  - Sweep counter runs 0..DEPTH-1, one entry per cycle.
  - Each cycle: cam_we=1, cam_valid=0, cam_data=0, cam_addr=counter.
  - After entry DEPTH-1: go to IDLE. Bitmap is all-free and used_count=0.
- **IDLE**
  - req_ready=1 only in this state.
  - On req_valid & req_ready: capture op and key into registers, go to LOOKUP.
- **LOOKUP**
  - lookup_data = captured key. lookup_data holds that key from the accept edge until the next accept.
  - Next state: CHECK.
- **CHECK**: lookup_hit and lookup_addr are valid this cycle.
  - Insert, hit: status EXISTS, rsp_addr=lookup_addr, go to RESP. No write.
  - Insert, miss, no free slot: status FULL, go to RESP.
  - Insert, miss, free slot available: target = lowest-index free slot. Go to WRITE with cam_valid=1, cam_data=key.
  - Delete, hit: target = lookup_addr. Go to WRITE with cam_valid=0, cam_data=0.
  - Delete, miss: status NOT_FOUND, go to RESP.
- **WRITE**
  - cam_we=1, cam_addr=target.
  - Insert: set the bitmap bit and increment used_count at the cycle end.
  - Delete: clear the bitmap bit and decrement used_count at the cycle end.
  - Status OK, rsp_addr=target. Go to RESP.
- **RESP**
  - rsp_valid=1; status and addr are stable.
  - On rsp_ready: go to IDLE.
- cam_we is 0 in every state other than INIT and WRITE.
- Free-slot search is a combinational priority encoder over the inverted bitmap. FULL means the bitmap is all ones (used_count==DEPTH).
- used_count never wraps; it is bounded by the bitmap.

## Timing
- Reset values: state=INIT, sweep counter=0, bitmap all-free, used_count=0, req_ready=0, rsp_valid=0, rsp_status=0, rsp_addr=0, lookup_data=0, init_busy=1.
  - cam_we=0 in the reset cycle. The sweep starts on the first cycle after reset deasserts.
- Flush takes exactly DEPTH cycles. req_ready first rises DEPTH cycles after reset deasserts.
- Accept on edge E0. rsp_valid rises:
  - 3 cycles after E0 for EXISTS, FULL and NOT_FOUND (states LOOKUP, CHECK, RESP);
  - 4 cycles after E0 for write cases (states LOOKUP, CHECK, WRITE, RESP).
- One request in flight at a time. A CAM write lands before the next request's lookup, so no read-after-write hazard exists.
- rsp_ready low holds the controller in RESP indefinitely; req_ready stays 0 meanwhile.
- Reset asserted in any state, including mid-sweep or mid-WRITE:
  - next state INIT; the sweep restarts at 0;
  - bitmap cleared; any pending response is dropped.
- Keys compare on all DATA_WIDTH bits. Key 0 is legal.

## Test plan
- Reset, release -> cam_we=1 with cam_valid=0 for addresses 0..31 (defaults) on consecutive cycles. req_ready=1 on cycle 32 after release; used_count=0.
- Insert 0xDEADBEEF -> write at addr 0 with cam_valid=1. rsp OK, addr 0, 4 cycles after accept; used_count=1.
- Insert 0xDEADBEEF again -> no cam_we, rsp EXISTS, addr 0, 3 cycles after accept.
- Insert 32 distinct keys, then 0x12345678 -> 33rd rsp FULL, addr 0, no write. Then delete the key at addr 5 -> write cam_valid=0 at addr 5, rsp OK. Then insert 0x12345678 -> lands at addr 5.
- Delete unknown key 0xCAFEF00D -> rsp NOT_FOUND, no cam_we, used_count unchanged. Hold rsp_ready=0 for 10 cycles -> rsp_valid and fields stable, req_ready=0.
- Assert reset during WRITE and again at sweep address 17 -> flush restarts at addr 0; used_count=0; rsp_valid=0; no response emitted for the aborted request.
